bnn_roll_sched: RTL and testbench
=================================

BNN_ROLL_SCHED -- requirements
Module: bnn_roll_sched

Interface
REQ-001 Parameter HIDDEN_CNT, default 40: number of hidden neurons evaluated serially in layer 0.
REQ-002 Parameter CLASS_CNT, default 6: number of class neurons evaluated serially in layer 1.
REQ-003 Parameter CNT_W, default 16: width of the completed-inference counter.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  a feature vector is presented to the datapath.
REQ-007 in_ready  out  1  scheduler can accept a feature vector.
REQ-008 flush  in  1  synchronous abort of the current inference.
REQ-009 feat_load  out  1  one-cycle strobe; datapath captures features.
REQ-010 hid_en  out  1  layer-0 neuron evaluation enable.
REQ-011 hid_idx  out  $clog2(HIDDEN_CNT)  hidden neuron being evaluated.
REQ-012 cls_en  out  1  layer-1 class score evaluation enable.
REQ-013 cls_idx  out  $clog2(CLASS_CNT)  class being evaluated.
REQ-014 out_valid  out  1  datapath prediction is final.
REQ-015 out_ready  in  1  consumer accepts the prediction.
REQ-016 done_cnt  out  CNT_W  completed (handed-off) inferences.

Function
REQ-017 The FSM SHALL have states IDLE, L0, L1 and DONE.
REQ-018 IDLE: in_ready=1 unless flush=1; in_valid&in_ready SHALL pulse feat_load in the same cycle and move to L0 with hid_idx=0.
REQ-019 L0: hid_en=1 every cycle, hid_idx increments by 1; in the cycle hid_idx=HIDDEN_CNT-1 the next state SHALL be L1 with cls_idx=0.
REQ-020 L1: cls_en=1 every cycle, cls_idx increments by 1; in the cycle cls_idx=CLASS_CNT-1 the next state SHALL be DONE.
REQ-021 DONE: out_valid=1, held stable until out_ready=1; on out_valid&out_ready the next state SHALL be IDLE and done_cnt SHALL increment.
REQ-022 Latency from accept edge to out_valid SHALL be exactly HIDDEN_CNT+CLASS_CNT+1 cycles (47 at defaults).
REQ-023 in_ready SHALL be 0 in L0, L1 and DONE; in_valid there is ignored.
REQ-024 flush=1 in any state SHALL force IDLE on the next edge, clear indices, suppress out_valid, and leave done_cnt unchanged.
REQ-025 flush and in_valid together in IDLE: flush wins, no feat_load, no accept.
REQ-026 flush and out_ready together in DONE: flush wins, done_cnt unchanged.
REQ-027 hid_en, cls_en, feat_load and out_valid SHALL be mutually exclusive.
REQ-028 Indices SHALL hold 0 when their enable is low.
REQ-029 done_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-030 All outputs SHALL be registered or decoded from state only; no combinational in-to-out path except in_ready/feat_load from flush/in_valid.

Reset
REQ-031 rst=1 SHALL immediately set state IDLE, hid_idx=0, cls_idx=0, done_cnt=0, so out_valid=hid_en=cls_en=feat_load=0.
REQ-032 Reset asserted mid-inference SHALL abandon it with no out_valid after release.
REQ-033 First accept SHALL be possible on the first edge after rst deasserts.

Structure
REQ-034 Shared package bnnroll_pkg SHALL hold the state enum and the index-width functions.
REQ-035 One sub-module roll_idx_cnt (parameterised modulo counter: en, clr, idx, last flag) SHALL be instantiated twice, for hid_idx and cls_idx.

Verification
REQ-036 Single inference, out_ready tied 1: in_valid at cycle 0 -> feat_load cycle 0, hid_en cycles 1-40 with hid_idx 0..39, cls_en cycles 41-46 with cls_idx 0..5, out_valid cycle 47, done_cnt=1.
REQ-037 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid held 11 cycles, in_ready=0 throughout, done_cnt increments once.
REQ-038 Flush at hid_idx=20 -> next cycle IDLE, in_ready=1, no out_valid, done_cnt unchanged; next in_valid restarts hid_idx at 0.
REQ-039 rst pulsed during L1 (cls_idx=3) -> outputs 0 asynchronously; fresh inference after release completes in 47 cycles.
REQ-040 in_valid held high continuously, out_ready=1 -> one accept every 48 cycles; 3 inferences give done_cnt=3.
REQ-041 CNT_W=2, 5 inferences -> done_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/bnn_roll_sched_pkg.sv
// ---------------------------------------------------------------------------
// bnnroll_pkg
//
// Shared definitions for the rolled binary-neural-network scheduler:
//   - state_e : scheduler states (idle, hidden layer, class layer, result)
//   - idx_w() : width of an index that counts 0..n-1, never narrower than
//               one bit so a single-neuron layer still has a legal port
// ---------------------------------------------------------------------------
package bnnroll_pkg;

   // Scheduler phases. IDLE waits for a feature vector, L0 walks the hidden
   // neurons, L1 walks the class neurons, DONE holds the prediction until the
   // consumer takes it.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_L0   = 2'd1,
      ST_L1   = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Index width for a counter that visits 0..n-1. $clog2(1) is 0, which
   // would give a zero-width vector, so clamp to one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/bnn_roll_sched_idx_cnt.sv
// ---------------------------------------------------------------------------
// roll_idx_cnt
//
// Modulo-CNT index counter used to step through the neurons of one layer.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears the index
//   en    in   advance the index this cycle
//   clr   in   synchronous clear, has priority over en
//   idx   out  current index, registered
//   last  out  index currently equals CNT-1 (decoded from the register)
//
// The index only moves while en is high and wraps back to zero after the
// last neuron, so it rests at zero whenever its layer is not active.
// ---------------------------------------------------------------------------
module roll_idx_cnt
   import bnnroll_pkg::*;
#(
   parameter int unsigned CNT = 4
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    clr,
   output logic [idx_w(CNT)-1:0]   idx,
   output logic                    last
);

   localparam int unsigned W = idx_w(CNT);
   localparam logic [W-1:0] LAST_IDX = W'(CNT - 1);

   logic [W-1:0] idx_q;
   logic [W-1:0] idx_d;

   assign last = (idx_q == LAST_IDX);
   assign idx  = idx_q;

   // Wrapping explicitly on the last index keeps non-power-of-two layer
   // sizes correct; clear beats enable so an abort always lands on zero.
   always_comb begin
      idx_d = idx_q;
      if (clr) begin
         idx_d = '0;
      end else if (en) begin
         idx_d = last ? '0 : idx_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/bnn_roll_sched.sv
// ---------------------------------------------------------------------------
// bnn_roll_sched
//
// Control scheduler for a rolled (time-multiplexed) two-layer binary neural
// network. One feature vector is accepted, then the hidden neurons are
// evaluated one per cycle, then the class neurons one per cycle, and the
// prediction is held until the consumer accepts it.
//
// Parameters:
//   HIDDEN_CNT  number of hidden neurons (layer 0)
//   CLASS_CNT   number of class neurons (layer 1)
//   CNT_W       width of the completed-inference counter
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   feature vector offered
//   in_ready   out  scheduler idle and able to accept
//   flush      in   synchronous abort of the current inference
//   feat_load  out  one-cycle strobe, datapath captures the features
//   hid_en     out  hidden neuron evaluation enable
//   hid_idx    out  hidden neuron being evaluated
//   cls_en     out  class neuron evaluation enable
//   cls_idx    out  class neuron being evaluated
//   out_valid  out  prediction is final
//   out_ready  in   consumer takes the prediction
//   done_cnt   out  number of predictions handed off (wraps)
//
// Timing: accept on edge 0, hidden neurons on cycles 1..HIDDEN_CNT, class
// neurons on the following CLASS_CNT cycles, out_valid on cycle
// HIDDEN_CNT+CLASS_CNT+1.
// ---------------------------------------------------------------------------
module bnn_roll_sched
   import bnnroll_pkg::*;
#(
   parameter int unsigned HIDDEN_CNT = 40,
   parameter int unsigned CLASS_CNT  = 6,
   parameter int unsigned CNT_W      = 16
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          flush,
   output logic                          feat_load,
   output logic                          hid_en,
   output logic [idx_w(HIDDEN_CNT)-1:0]  hid_idx,
   output logic                          cls_en,
   output logic [idx_w(CLASS_CNT)-1:0]   cls_idx,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CNT_W-1:0]              done_cnt
);

   state_e            state_q;
   state_e            state_d;
   logic [CNT_W-1:0]  done_cnt_q;
   logic [CNT_W-1:0]  done_cnt_d;
   logic              hid_last;
   logic              cls_last;

   // Hidden-layer index. It advances while the hidden layer is active and
   // is cleared by an abort so the next inference starts from neuron 0.
   roll_idx_cnt #(
      .CNT (HIDDEN_CNT)
   ) u_hid_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (hid_en),
      .clr  (flush),
      .idx  (hid_idx),
      .last (hid_last)
   );

   // Class-layer index, same behaviour for the second layer.
   roll_idx_cnt #(
      .CNT (CLASS_CNT)
   ) u_cls_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (cls_en),
      .clr  (flush),
      .idx  (cls_idx),
      .last (cls_last)
   );

   // Next-state and output decode. Enables and out_valid come from the
   // state register alone; only the accept handshake (in_ready/feat_load)
   // looks at inputs. in_ready is also held low while reset is asserted so
   // nothing can appear to be accepted by a scheduler that is being cleared.
   // A flush overrides whatever the state would have done, including a
   // pending accept or hand-off, and leaves the completion count untouched.
   always_comb begin
      state_d    = state_q;
      done_cnt_d = done_cnt_q;
      in_ready   = 1'b0;
      feat_load  = 1'b0;
      hid_en     = 1'b0;
      cls_en     = 1'b0;
      out_valid  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready  = ~flush & ~rst;
            feat_load = in_valid & ~flush & ~rst;
            if (feat_load) begin
               state_d = ST_L0;
            end
         end
         ST_L0: begin
            hid_en = 1'b1;
            if (hid_last) begin
               state_d = ST_L1;
            end
         end
         ST_L1: begin
            cls_en = 1'b1;
            if (cls_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d    = ST_IDLE;
               done_cnt_d = done_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (flush) begin
         state_d    = ST_IDLE;
         done_cnt_d = done_cnt_q;
      end
   end

   // State and completion-count registers. The counter wraps naturally at
   // its width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_bnn_roll_sched.sv
// ---------------------------------------------------------------------------
// tb_bnn_roll_sched
//
// Drives directed scenarios followed by random traffic into bnn_roll_sched.
// A reference model counts cycles since the last accept and derives the
// expected enables, indices and counts from that elapsed time. Each accept
// pushes an expected hand-off into a scoreboard queue; a separate monitor
// pops it when the DUT presents its result and checks latency and count.
// ---------------------------------------------------------------------------
module tb_bnn_roll_sched;

   localparam int H   = 40;
   localparam int C   = 6;
   localparam int CW  = 2;
   localparam int LAT = H + C + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic          feat_load;
   logic          hid_en;
   logic [5:0]    hid_idx;
   logic          cls_en;
   logic [2:0]    cls_idx;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] done_cnt;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   typedef struct {
      int acc_cyc;
      int exp_cnt;
   } sb_t;

   sb_t sb_q[$];

   bnn_roll_sched #(
      .HIDDEN_CNT (H),
      .CLASS_CNT  (C),
      .CNT_W      (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .feat_load (feat_load),
      .hid_en    (hid_en),
      .hid_idx   (hid_idx),
      .cls_en    (cls_en),
      .cls_idx   (cls_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sets inputs for the current cycle and advances to just after the next edge.
   task automatic applyStimulus(input logic iv, input logic orr, input logic fl);
      in_valid  = iv;
      out_ready = orr;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   // Reference model: an inference is "busy" with m_k cycles elapsed since
   // its accept. Hidden neuron k-1 runs on elapsed cycle k (1..H), class
   // neuron k-H-1 on cycles H+1..H+C, and the result is valid from H+C+1.
   bit m_busy = 1'b0;
   int m_k    = 0;
   int m_cnt  = 0;
   bit e_ir, e_fl, e_he, e_ce, e_ov;
   int e_hid, e_cls;

   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rst_flags", 32'({in_ready, feat_load, hid_en, cls_en, out_valid}), 32'd0);
         checkOutput("rst_idx", 32'({hid_idx, cls_idx}), 32'd0);
         checkOutput("rst_done_cnt", 32'(done_cnt), 32'd0);
         m_busy = 1'b0;
         m_k    = 0;
         m_cnt  = 0;
      end else begin
         e_ir  = !m_busy && !flush;
         e_fl  = !m_busy && in_valid && !flush;
         e_he  = m_busy && (m_k >= 1) && (m_k <= H);
         e_ce  = m_busy && (m_k > H) && (m_k <= H + C);
         e_ov  = m_busy && (m_k > H + C);
         e_hid = e_he ? m_k - 1 : 0;
         e_cls = e_ce ? m_k - H - 1 : 0;
         checkOutput("flags", 32'({in_ready, feat_load, hid_en, cls_en, out_valid}),
                     32'({e_ir, e_fl, e_he, e_ce, e_ov}));
         checkOutput("hid_idx", 32'(hid_idx), 32'(e_hid));
         checkOutput("cls_idx", 32'(cls_idx), 32'(e_cls));
         checkOutput("done_cnt", 32'(done_cnt), 32'(m_cnt));
         if (flush) begin
            m_busy = 1'b0;
         end else if (!m_busy) begin
            if (in_valid) begin
               m_busy = 1'b1;
               m_k    = 1;
               sb_q.push_back('{acc_cyc: cyc, exp_cnt: (m_cnt + 1) % (1 << CW)});
            end
         end else if (e_ov) begin
            if (out_ready) begin
               m_busy = 1'b0;
               m_cnt  = (m_cnt + 1) % (1 << CW);
            end
         end else begin
            m_k++;
         end
      end
   end

   // Scoreboard monitor: watches the DUT's result handshake and retires the
   // expected entries pushed on accept; aborts retire them silently.
   bit prev_ov  = 1'b0;
   bit pend     = 1'b0;
   int pend_val = 0;

   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         pend    = 1'b0;
         prev_ov = 1'b0;
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else begin
         if (pend) begin
            checkOutput("sb_done_cnt", 32'(done_cnt), 32'(pend_val));
            pend = 1'b0;
         end
         if (flush) begin
            prev_ov = 1'b0;
            if (sb_q.size() > 0) void'(sb_q.pop_front());
         end else begin
            if (out_valid && !prev_ov) begin
               if (sb_q.size() == 0) checkOutput("sb_unexpected_out_valid", 32'd1, 32'd0);
               else checkOutput("sb_latency", 32'(cyc - sb_q[0].acc_cyc), 32'(LAT));
            end
            if (out_valid && out_ready && sb_q.size() > 0) begin
               pend     = 1'b1;
               pend_val = sb_q[0].exp_cnt;
               void'(sb_q.pop_front());
            end
            prev_ov = out_valid;
         end
      end
   end

   initial begin
      int n;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b1;
      #1;
      checkOutput("reset_outputs", 32'({hid_en, cls_en, out_valid, feat_load}), 32'd0);
      checkOutput("reset_done_cnt", 32'(done_cnt), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Single inference, accepted on the first edge after reset release.
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("first_accept_hid_en", 32'(hid_en), 32'd1);
      repeat (50) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("single_done_cnt", 32'(done_cnt), 32'd1);

      // Backpressure: hold the result for 10 extra cycles.
      applyStimulus(1'b1, 1'b0, 1'b0);
      n = 0;
      while (!out_valid && n < 100) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         n++;
      end
      checkOutput("bp_reach_done", 32'(n < 100), 32'd1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput("bp_held", 32'({out_valid, in_ready}), 32'b10);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("bp_released", 32'({out_valid, in_ready, done_cnt}), 32'({2'b01, 2'd2}));

      // Flush while hidden neuron 20 is being evaluated.
      applyStimulus(1'b1, 1'b1, 1'b0);
      n = 0;
      while (hid_idx != 6'd20 && n < 100) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         n++;
      end
      checkOutput("flush_reach_20", 32'(n < 100), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      in_valid = 1'b0;
      flush    = 1'b0;
      #1;
      checkOutput("flush_idle", 32'({in_ready, hid_en, out_valid, hid_idx}), 32'({3'b100, 6'd0}));
      checkOutput("flush_done_cnt", 32'(done_cnt), 32'd2);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("restart_hid", 32'({hid_en, hid_idx}), 32'({1'b1, 6'd0}));
      repeat (50) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("restart_done_cnt", 32'(done_cnt), 32'd3);

      // Reset during the class layer at class 3.
      applyStimulus(1'b1, 1'b1, 1'b0);
      n = 0;
      while (!(cls_en && cls_idx == 3'd3) && n < 100) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         n++;
      end
      checkOutput("rst_reach_cls3", 32'(n < 100), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("async_rst", 32'({hid_en, cls_en, out_valid, feat_load, cls_idx, done_cnt}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      n = 1;
      while (!out_valid && n < 100) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         n++;
      end
      checkOutput("post_rst_latency", 32'(n), 32'(LAT));
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("post_rst_done_cnt", 32'(done_cnt), 32'd1);

      // in_valid held high: three back-to-back inferences, count wraps 3->0.
      repeat (3 * (LAT + 1)) applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("stream_done_cnt", 32'(done_cnt), 32'd0);

      // flush beats in_valid in IDLE.
      in_valid = 1'b1;
      flush    = 1'b1;
      #1;
      checkOutput("flush_vs_accept", 32'({in_ready, feat_load}), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("flush_vs_accept_next", 32'(hid_en), 32'd0);

      // flush beats out_ready in DONE.
      applyStimulus(1'b1, 1'b0, 1'b0);
      n = 0;
      while (!out_valid && n < 100) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         n++;
      end
      checkOutput("flush_done_reach", 32'(n < 100), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("flush_vs_handoff", 32'({out_valid, done_cnt}), 32'd0);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 1499) == 0) rst = 1'b1;
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 199) == 0));
         rst = 1'b0;
      end

      repeat (60) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
